frame_stream_writer: RTL and testbench

FRAME_STREAM_WRITER -- requirements
Module: frame_stream_writer

---
 rtl/frame_stream_writer_pkg.sv | 21 ++
 rtl/frame_stream_writer.sv | 128 ++++++++++++
 tb/tb_frame_stream_writer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_stream_writer_pkg.sv
// Shared types and helpers for the Avalon-ST to frame-buffer writer.
// Optional statistics counters are enabled with FRAME_STREAM_WRITER_STATS_EN.
package frame_stream_writer_pkg;

    localparam int DEFAULT_WIDTH  = 320;
    localparam int DEFAULT_HEIGHT = 240;
    localparam int PIX_IN_W       = 30;
    localparam int PIX_OUT_W      = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Keep the top 4 bits of each 10-bit colour channel: R4 G4 B4.
    function automatic logic [PIX_OUT_W-1:0] pack_pixel(input logic [PIX_IN_W-1:0] pix);
        return {pix[29:26], pix[19:16], pix[9:6]};
    endfunction

endpackage

// File: rtl/frame_stream_writer.sv
// Writes one Avalon-ST video frame into a 12-bit frame buffer, flagging short/long packets.
// Define FRAME_STREAM_WRITER_STATS_EN to add saturating frame_count/err_count outputs.
module frame_stream_writer
    import frame_stream_writer_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int ADDR_W = 17
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PIX_IN_W-1:0]  sink_data,
    input  logic                 sink_valid,
    input  logic                 sink_startofpacket,
    input  logic                 sink_endofpacket,
    output logic                 sink_ready,
    input  logic                 freeze,
    output logic [ADDR_W-1:0]    wraddress,
    output logic [PIX_OUT_W-1:0] wrdata,
    output logic                 wren,
    output logic                 frame_done,
    output logic                 err_short,
    output logic                 err_long
`ifdef FRAME_STREAM_WRITER_STATS_EN
    ,
    output logic [15:0]          frame_count,
    output logic [15:0]          err_count
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_cnt, addr_cnt_nx, pix_addr;
    logic              beat, do_write, done_nx, short_nx, long_nx;

    assign beat = sink_valid && sink_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nx    = state;
        addr_cnt_nx = addr_cnt;
        pix_addr    = addr_cnt;
        do_write    = 1'b0;
        done_nx     = 1'b0;
        short_nx    = 1'b0;
        long_nx     = 1'b0;

        if (beat) begin
            // SOP is resolved first so a SOP+EOP beat falls through to the EOP handling below.
            if (sink_startofpacket) begin
                if (state == WRITE) begin
                    short_nx = 1'b1;
                    do_write = 1'b1;
                    pix_addr = '0;
                end else if (!freeze) begin
                    do_write = 1'b1;
                    pix_addr = '0;
                end else begin
                    state_nx = DISCARD;
                end
            end else if (state == WRITE) begin
                do_write = 1'b1;
            end

            if (do_write) begin
                if (sink_endofpacket) begin
                    state_nx    = IDLE;
                    addr_cnt_nx = '0;
                    if (pix_addr == LAST_ADDR) done_nx  = 1'b1;
                    else                       short_nx = 1'b1;
                end else if (pix_addr == LAST_ADDR) begin
                    long_nx     = 1'b1;
                    state_nx    = DISCARD;
                    addr_cnt_nx = '0;
                end else begin
                    state_nx    = WRITE;
                    addr_cnt_nx = pix_addr + ADDR_W'(1);
                end
            end else if (sink_endofpacket) begin
                state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= IDLE;
            addr_cnt   <= '0;
            sink_ready <= 1'b0;
            wren       <= 1'b0;
            wraddress  <= '0;
            wrdata     <= '0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
        end else begin
            state      <= state_nx;
            addr_cnt   <= addr_cnt_nx;
            sink_ready <= 1'b1;
            wren       <= do_write;
            frame_done <= done_nx;
            err_short  <= short_nx;
            err_long   <= long_nx;
            if (do_write) begin
                wraddress <= pix_addr;
                wrdata    <= pack_pixel(sink_data);
            end
        end
    end

`ifdef FRAME_STREAM_WRITER_STATS_EN
    // Counters advance in the same cycle their status pulse is registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (done_nx && frame_count != 16'hFFFF)
                frame_count <= frame_count + 16'd1;
            if ((short_nx || long_nx) && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_stream_writer.sv
// Directed bench for frame_stream_writer on a reduced 16x8 frame.
// With FRAME_STREAM_WRITER_STATS_EN defined the statistics ports are also connected and checked.
module tb_frame_stream_writer;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int T  = W * H;
    localparam int AW = 17;

    logic          clk;
    logic          reset_n;
    logic [29:0]   sink_data;
    logic          sink_valid, sink_startofpacket, sink_endofpacket;
    logic          sink_ready;
    logic          freeze;
    logic [AW-1:0] wraddress;
    logic [11:0]   wrdata;
    logic          wren, frame_done, err_short, err_long;
`ifdef FRAME_STREAM_WRITER_STATS_EN
    logic [15:0]   frame_count, err_count;
`endif

    frame_stream_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .sink_data          (sink_data),
        .sink_valid         (sink_valid),
        .sink_startofpacket (sink_startofpacket),
        .sink_endofpacket   (sink_endofpacket),
        .sink_ready         (sink_ready),
        .freeze             (freeze),
        .wraddress          (wraddress),
        .wrdata             (wrdata),
        .wren               (wren),
        .frame_done         (frame_done),
        .err_short          (err_short),
        .err_long           (err_long)
`ifdef FRAME_STREAM_WRITER_STATS_EN
        ,
        .frame_count        (frame_count),
        .err_count          (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Write/pulse monitor, sampled on the falling edge.
    logic [AW-1:0] addr_q[$];
    logic [11:0]   data_q[$];
    int n_done, n_short, n_long, n_misalign;
    int done_addr, short_addr, long_addr;

    always @(negedge clk) begin
        if (wren) begin
            addr_q.push_back(wraddress);
            data_q.push_back(wrdata);
        end
        if ((frame_done || err_short || err_long) && !wren) n_misalign++;
        if (frame_done) begin n_done++;  done_addr  = int'(wraddress); end
        if (err_short)  begin n_short++; short_addr = int'(wraddress); end
        if (err_long)   begin n_long++;  long_addr  = int'(wraddress); end
    end

    task automatic clear_mon();
        addr_q.delete();
        data_q.delete();
        n_done = 0; n_short = 0; n_long = 0; n_misalign = 0;
        done_addr = -1; short_addr = -1; long_addr = -1;
    endtask

    function automatic logic [29:0] pix(input int i);
        logic [9:0] a;
        a = i[9:0];
        return {a, 10'(i * 7), a ^ 10'h155};
    endfunction

    function automatic logic [11:0] exp_pack(input logic [29:0] d);
        return {d[29:26], d[19:16], d[9:6]};
    endfunction

    function automatic int addr_errs(input int start, input int n, input int base);
        int e = 0;
        for (int k = 0; k < n; k++)
            if (start + k >= addr_q.size() || addr_q[start + k] !== AW'(base + k)) e++;
        return e;
    endfunction

    function automatic int data_errs(input int start, input int n);
        int e = 0;
        for (int k = 0; k < n; k++)
            if (start + k >= data_q.size() || data_q[start + k] !== exp_pack(pix(k))) e++;
        return e;
    endfunction

    task automatic quiet();
        sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0; freeze = 1'b0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n beats, SOP on beat 0, EOP on beat eop_at (-1 for none); freeze flips after the SOP beat.
    task automatic stream(input int n, input int eop_at, input bit fz);
        for (int i = 0; i < n; i++) begin
            sink_valid         = 1'b1;
            sink_startofpacket = (i == 0);
            sink_endofpacket   = (i == eop_at);
            freeze             = (i == 0) ? fz : !fz;
            sink_data          = pix(i);
            @(posedge clk);
            #1;
        end
        quiet();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        quiet();
        sink_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sink_ready, wren, frame_done, err_short, err_long} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {sink_ready, wren, frame_done, err_short, err_long});
        end
        checks++;
        if (wraddress !== '0 || wrdata !== '0) begin
            failures++;
            $display("FAIL reset_bus got addr=%0d data=%h exp 0/0", wraddress, wrdata);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sink_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=1", sink_ready);
        end
    endtask

    task automatic test_pack_single();
        clear_mon();
        sink_valid = 1'b1; sink_startofpacket = 1'b1; sink_endofpacket = 1'b1; freeze = 1'b0;
        sink_data = 30'h3FF_003FF;
        sink_data = {10'h3FF, 10'h000, 10'h3FF};
        @(posedge clk);
        #1;
        checks++;
        if ({wren, wraddress, wrdata} !== {1'b1, AW'(0), 12'hF0F}) begin
            failures++;
            $display("FAIL pack_write got wren=%b addr=%0d data=%h exp 1/0/f0f", wren, wraddress, wrdata);
        end
        checks++;
        if ({frame_done, err_short, err_long} !== 3'b010) begin
            failures++;
            $display("FAIL single_pixel_status got=%b exp=010", {frame_done, err_short, err_long});
        end
        sink_startofpacket = 1'b0; sink_endofpacket = 1'b0;
        sink_data = {10'h000, 10'h3FF, 10'h000};
        @(posedge clk);
        #1;
        checks++;
        if ({wren, err_short} !== 2'b00) begin
            failures++;
            $display("FAIL idle_drop got wren=%b err_short=%b exp 0/0", wren, err_short);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        clear_mon();
        stream(T, T - 1, 1'b0);
        stream(T, T - 1, 1'b0);
        idle(2);
        checks++;
        if (addr_q.size() !== 2 * T) begin
            failures++;
            $display("FAIL b2b_writes got=%0d exp=%0d", addr_q.size(), 2 * T);
        end
        checks++;
        if (addr_errs(0, T, 0) + addr_errs(T, T, 0) !== 0) begin
            failures++;
            $display("FAIL b2b_addr_order got=%0d bad exp=0", addr_errs(0, T, 0) + addr_errs(T, T, 0));
        end
        checks++;
        if (data_errs(0, T) !== 0) begin
            failures++;
            $display("FAIL b2b_data got=%0d bad exp=0", data_errs(0, T));
        end
        checks++;
        if (n_done !== 2 || done_addr !== T - 1 || n_short !== 0 || n_long !== 0) begin
            failures++;
            $display("FAIL b2b_status got done=%0d@%0d short=%0d long=%0d exp 2@%0d/0/0",
                     n_done, done_addr, n_short, n_long, T - 1);
        end
        checks++;
        if (n_misalign !== 0) begin
            failures++;
            $display("FAIL pulse_alignment got=%0d exp=0", n_misalign);
        end
    endtask

    task automatic test_short();
        clear_mon();
        stream(101, 100, 1'b0);
        idle(2);
        checks++;
        if (addr_q.size() !== 101 || n_short !== 1 || short_addr !== 100 || n_done !== 0) begin
            failures++;
            $display("FAIL short_eop got writes=%0d short=%0d@%0d done=%0d exp 101/1@100/0",
                     addr_q.size(), n_short, short_addr, n_done);
        end
        stream(T, T - 1, 1'b0);
        idle(2);
        checks++;
        if (addr_errs(101, T, 0) !== 0 || n_done !== 1) begin
            failures++;
            $display("FAIL short_recover got bad=%0d done=%0d exp 0/1", addr_errs(101, T, 0), n_done);
        end
    endtask

    task automatic test_midframe_sop();
        clear_mon();
        stream(50, -1, 1'b0);
        stream(T, T - 1, 1'b0);
        idle(2);
        checks++;
        if (addr_q.size() !== 50 + T || addr_errs(0, 50, 0) + addr_errs(50, T, 0) !== 0) begin
            failures++;
            $display("FAIL midsop_writes got=%0d exp=%0d", addr_q.size(), 50 + T);
        end
        checks++;
        if (n_short !== 1 || short_addr !== 0 || n_done !== 1 || n_long !== 0) begin
            failures++;
            $display("FAIL midsop_status got short=%0d@%0d done=%0d long=%0d exp 1@0/1/0",
                     n_short, short_addr, n_done, n_long);
        end
    endtask

    task automatic test_long();
        clear_mon();
        stream(T + 5, T + 4, 1'b0);
        idle(2);
        checks++;
        if (addr_q.size() !== T || addr_errs(0, T, 0) !== 0) begin
            failures++;
            $display("FAIL long_writes got=%0d exp=%0d", addr_q.size(), T);
        end
        checks++;
        if (n_long !== 1 || long_addr !== T - 1 || n_short !== 0 || n_done !== 0) begin
            failures++;
            $display("FAIL long_status got long=%0d@%0d short=%0d done=%0d exp 1@%0d/0/0",
                     n_long, long_addr, n_short, n_done, T - 1);
        end
        stream(3, 2, 1'b0);
        idle(2);
        checks++;
        if (addr_q.size() !== T + 3 || addr_errs(T, 3, 0) !== 0) begin
            failures++;
            $display("FAIL long_recover got writes=%0d exp=%0d", addr_q.size(), T + 3);
        end
    endtask

    task automatic test_freeze();
        clear_mon();
        stream(T, T - 1, 1'b0);
        stream(T, T - 1, 1'b1);
        checks++;
        if (addr_q.size() !== T) begin
            failures++;
            $display("FAIL freeze_frame2 got writes=%0d exp=%0d", addr_q.size(), T);
        end
        stream(T, T - 1, 1'b0);
        idle(2);
        checks++;
        if (addr_q.size() !== 2 * T || addr_errs(T, T, 0) !== 0 || n_done !== 2) begin
            failures++;
            $display("FAIL freeze_frame3 got writes=%0d done=%0d exp %0d/2", addr_q.size(), n_done, 2 * T);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        stream(50, -1, 1'b0);
        reset_n = 1'b0;
        sink_valid = 1'b1; sink_data = pix(50);
        @(posedge clk);
        #1;
        checks++;
        if ({wren, sink_ready} !== 2'b00) begin
            failures++;
            $display("FAIL midreset_outputs got wren=%b ready=%b exp 0/0", wren, sink_ready);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({wren, sink_ready} !== 2'b01) begin
            failures++;
            $display("FAIL midreset_release got wren=%b ready=%b exp 0/1", wren, sink_ready);
        end
        for (int i = 0; i < 10; i++) begin
            sink_valid = 1'b1; sink_data = pix(51 + i);
            @(posedge clk);
            #1;
        end
        idle(2);
        checks++;
        if (addr_q.size() !== 50) begin
            failures++;
            $display("FAIL midreset_drop got writes=%0d exp=50", addr_q.size());
        end
        stream(T, T - 1, 1'b0);
        idle(2);
        checks++;
        if (addr_errs(50, T, 0) !== 0 || n_done !== 1) begin
            failures++;
            $display("FAIL midreset_recover got bad=%0d done=%0d exp 0/1", addr_errs(50, T, 0), n_done);
        end
`ifdef FRAME_STREAM_WRITER_STATS_EN
        checks++;
        if (frame_count !== 16'd1 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL stats got frames=%0d errs=%0d exp 1/0", frame_count, err_count);
        end
`endif
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_pack_single();
        test_back_to_back();
        test_short();
        test_midframe_sop();
        test_long();
        test_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
